// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module : dispatch_queue
// Instruction buffer plus decode/operand-resolve stage feeding a registered
// issue slot; the held slot keeps snooping the CDBs while stalled.
// Rev    : 1.0  initial release
// ============================================================================
module dispatch_queue #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4,
  parameter int REG_IDX_W = 5,
  parameter int OPTYPE_W  = 4,
  parameter int OPENUM_W  = 6,
  parameter int NUM_CDB   = 2,
  parameter int IQ_DEPTH  = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         if_to_dc_valid,
  input  logic [31:0]                  if_to_dc_inst,
  input  logic [XLEN-1:0]              if_to_dc_PC,
  input  logic [OPTYPE_W-1:0]          if_to_dc_opType,
  input  logic [OPENUM_W-1:0]          if_to_dc_op,
  output logic                         dc_to_if_ready,
  output logic [REG_IDX_W-1:0]         dc_to_reg_rs1_pos,
  output logic [REG_IDX_W-1:0]         dc_to_reg_rs2_pos,
  input  logic [XLEN-1:0]              reg_to_dc_rs1_val,
  input  logic [XLEN-1:0]              reg_to_dc_rs2_val,
  input  logic [ROB_IDX_W-1:0]         reg_to_dc_rs1_depend,
  input  logic [ROB_IDX_W-1:0]         reg_to_dc_rs2_depend,
  input  logic                         rob_to_dc_rs1_ready,
  input  logic                         rob_to_dc_rs2_ready,
  input  logic [XLEN-1:0]              rob_to_dc_rs1_val,
  input  logic [XLEN-1:0]              rob_to_dc_rs2_val,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob_index,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_val,
  input  logic                         rob_full,
  input  logic                         rs_ready,
  output logic                         issue_valid,
  output logic [OPENUM_W-1:0]          issue_op,
  output logic [REG_IDX_W-1:0]         issue_rd,
  output logic [XLEN-1:0]              issue_imm,
  output logic [XLEN-1:0]              issue_PC,
  output logic [XLEN-1:0]              issue_rs1_val,
  output logic [XLEN-1:0]              issue_rs2_val,
  output logic [ROB_IDX_W-1:0]         issue_rs1_depend,
  output logic [ROB_IDX_W-1:0]         issue_rs2_depend
);

  localparam int c_PTR_W = $clog2(IQ_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  // Instruction class encoding shared with the fetch unit's `OP_* codes
  localparam logic [OPTYPE_W-1:0] c_OP_RC    = OPTYPE_W'(1);
  localparam logic [OPTYPE_W-1:0] c_OP_RI    = OPTYPE_W'(2);
  localparam logic [OPTYPE_W-1:0] c_OP_LD    = OPTYPE_W'(3);
  localparam logic [OPTYPE_W-1:0] c_OP_ST    = OPTYPE_W'(4);
  localparam logic [OPTYPE_W-1:0] c_OP_BR    = OPTYPE_W'(5);
  localparam logic [OPTYPE_W-1:0] c_OP_JAL   = OPTYPE_W'(6);
  localparam logic [OPTYPE_W-1:0] c_OP_JALR  = OPTYPE_W'(7);
  localparam logic [OPTYPE_W-1:0] c_OP_LUI   = OPTYPE_W'(8);
  localparam logic [OPTYPE_W-1:0] c_OP_AUIPC = OPTYPE_W'(9);

  // Opcode bits [6:0] are implied by opType and are not buffered
  logic [24:0]         r_inst_q [IQ_DEPTH];
  logic [XLEN-1:0]     r_pc_q   [IQ_DEPTH];
  logic [OPTYPE_W-1:0] r_type_q [IQ_DEPTH];
  logic [OPENUM_W-1:0] r_op_q   [IQ_DEPTH];
  logic [c_PTR_W-1:0]  r_head, r_tail;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_enq, w_accept, w_load;
  logic [31:0]         w_inst, w_imm32;
  logic [OPTYPE_W-1:0] w_type;
  logic [XLEN-1:0]     w_imm;
  logic [REG_IDX_W-1:0] w_rd;
  logic                w_use_rs1, w_use_rs2;
  logic [XLEN:0]       w_cdb1, w_cdb2, w_snp1, w_snp2;
  logic [XLEN-1:0]     w_rs1_val, w_rs2_val;
  logic [ROB_IDX_W-1:0] w_rs1_dep, w_rs2_dep;

  // Returns {hit, value}; the lowest-index matching bus wins
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_IDX_W-1:0]         tag,
    input logic [NUM_CDB-1:0]           vld,
    input logic [NUM_CDB*ROB_IDX_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]      vals
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*ROB_IDX_W +: ROB_IDX_W] == tag)
        res = {1'b1, vals[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  function automatic logic [XLEN+ROB_IDX_W-1:0] resolve(
    input logic                 use_rs,
    input logic [REG_IDX_W-1:0] pos,
    input logic [XLEN-1:0]      reg_val,
    input logic [ROB_IDX_W-1:0] dep,
    input logic                 rob_rdy,
    input logic [XLEN-1:0]      rob_val,
    input logic [XLEN:0]        cdb_hit
  );
    if (!use_rs)                    return '0;
    if (pos == '0 || dep == '0)     return {reg_val, ROB_IDX_W'(0)};
    if (rob_rdy)                    return {rob_val, ROB_IDX_W'(0)};
    if (cdb_hit[XLEN])              return {cdb_hit[XLEN-1:0], ROB_IDX_W'(0)};
    return {XLEN'(0), dep};
  endfunction

  assign dc_to_if_ready = (r_count != c_CNT_W'(IQ_DEPTH));
  assign w_enq    = if_to_dc_valid & dc_to_if_ready;
  assign w_accept = issue_valid & rs_ready & ~rob_full;
  assign w_load   = (r_count != '0) & (~issue_valid | w_accept);

  assign w_inst = {r_inst_q[r_head], 7'b0};
  assign w_type = r_type_q[r_head];
  assign dc_to_reg_rs1_pos = w_inst[19:15];
  assign dc_to_reg_rs2_pos = w_inst[24:20];

  always_comb begin
    w_imm32   = '0;
    w_rd      = w_inst[11:7];
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b1;
    case (w_type)
      c_OP_LUI, c_OP_AUIPC: begin
        w_imm32   = {w_inst[31:12], 12'b0};
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
      end
      c_OP_JAL: begin
        w_imm32   = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
      end
      c_OP_JALR, c_OP_RI, c_OP_LD: begin
        w_imm32   = {{20{w_inst[31]}}, w_inst[31:20]};
        w_use_rs2 = 1'b0;
      end
      c_OP_BR: begin
        w_imm32 = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        w_rd    = '0;
      end
      c_OP_ST: begin
        w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
        w_rd    = '0;
      end
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm  = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
  assign w_cdb1 = cdb_lookup(reg_to_dc_rs1_depend, cdb_valid, cdb_rob_index, cdb_val);
  assign w_cdb2 = cdb_lookup(reg_to_dc_rs2_depend, cdb_valid, cdb_rob_index, cdb_val);
  assign w_snp1 = cdb_lookup(issue_rs1_depend, cdb_valid, cdb_rob_index, cdb_val);
  assign w_snp2 = cdb_lookup(issue_rs2_depend, cdb_valid, cdb_rob_index, cdb_val);
  assign {w_rs1_val, w_rs1_dep} = resolve(w_use_rs1, dc_to_reg_rs1_pos, reg_to_dc_rs1_val,
                                          reg_to_dc_rs1_depend, rob_to_dc_rs1_ready,
                                          rob_to_dc_rs1_val, w_cdb1);
  assign {w_rs2_val, w_rs2_dep} = resolve(w_use_rs2, dc_to_reg_rs2_pos, reg_to_dc_rs2_val,
                                          reg_to_dc_rs2_depend, rob_to_dc_rs2_ready,
                                          rob_to_dc_rs2_val, w_cdb2);

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in && w_enq) begin
      r_inst_q[r_tail] <= if_to_dc_inst[31:7];
      r_pc_q[r_tail]   <= if_to_dc_PC;
      r_type_q[r_tail] <= if_to_dc_opType;
      r_op_q[r_tail]   <= if_to_dc_op;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      issue_valid      <= 1'b0;
      issue_op         <= '0;
      issue_rd         <= '0;
      issue_imm        <= '0;
      issue_PC         <= '0;
      issue_rs1_val    <= '0;
      issue_rs2_val    <= '0;
      issue_rs1_depend <= '0;
      issue_rs2_depend <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
        issue_valid <= 1'b0;
      end else begin
        if (w_enq)  r_tail <= r_tail + c_PTR_W'(1);
        if (w_load) r_head <= r_head + c_PTR_W'(1);
        r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_load);
        if (w_load) begin
          issue_valid      <= 1'b1;
          issue_op         <= r_op_q[r_head];
          issue_rd         <= w_rd;
          issue_imm        <= w_imm;
          issue_PC         <= r_pc_q[r_head];
          issue_rs1_val    <= w_rs1_val;
          issue_rs2_val    <= w_rs2_val;
          issue_rs1_depend <= w_rs1_dep;
          issue_rs2_depend <= w_rs2_dep;
        end else if (w_accept) begin
          issue_valid <= 1'b0;
        end else if (issue_valid) begin
          // Stalled: wake pending operands in place from the result buses
          if (issue_rs1_depend != '0 && w_snp1[XLEN]) begin
            issue_rs1_val    <= w_snp1[XLEN-1:0];
            issue_rs1_depend <= '0;
          end
          if (issue_rs2_depend != '0 && w_snp2[XLEN]) begin
            issue_rs2_val    <= w_snp2[XLEN-1:0];
            issue_rs2_depend <= '0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_dispatch_queue
// Directed vector table plus hand-written corner sequences for dispatch_queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dispatch_queue;

  localparam logic [3:0] c_RC = 4'd1, c_RI = 4'd2, c_LD = 4'd3, c_ST = 4'd4, c_BR = 4'd5;
  localparam logic [3:0] c_JAL = 4'd6, c_JALR = 4'd7, c_LUI = 4'd8, c_AUIPC = 4'd9;
  localparam logic [31:0] c_ADD = 32'h002081B3;  // add x3,x1,x2

  logic        clk_in = 1'b0, rst_in, rdy_in, flush_in;
  logic        if_to_dc_valid;
  logic [31:0] if_to_dc_inst, if_to_dc_PC;
  logic [3:0]  if_to_dc_opType;
  logic [5:0]  if_to_dc_op;
  logic        dc_to_if_ready;
  logic [4:0]  dc_to_reg_rs1_pos, dc_to_reg_rs2_pos;
  logic [31:0] reg_to_dc_rs1_val, reg_to_dc_rs2_val;
  logic [3:0]  reg_to_dc_rs1_depend, reg_to_dc_rs2_depend;
  logic        rob_to_dc_rs1_ready, rob_to_dc_rs2_ready;
  logic [31:0] rob_to_dc_rs1_val, rob_to_dc_rs2_val;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_index;
  logic [63:0] cdb_val;
  logic        rob_full, rs_ready;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] issue_imm, issue_PC, issue_rs1_val, issue_rs2_val;
  logic [3:0]  issue_rs1_depend, issue_rs2_depend;

  int errors = 0;
  int checks = 0;

  dispatch_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_to_dc_valid(if_to_dc_valid), .if_to_dc_inst(if_to_dc_inst),
    .if_to_dc_PC(if_to_dc_PC), .if_to_dc_opType(if_to_dc_opType), .if_to_dc_op(if_to_dc_op),
    .dc_to_if_ready(dc_to_if_ready),
    .dc_to_reg_rs1_pos(dc_to_reg_rs1_pos), .dc_to_reg_rs2_pos(dc_to_reg_rs2_pos),
    .reg_to_dc_rs1_val(reg_to_dc_rs1_val), .reg_to_dc_rs2_val(reg_to_dc_rs2_val),
    .reg_to_dc_rs1_depend(reg_to_dc_rs1_depend), .reg_to_dc_rs2_depend(reg_to_dc_rs2_depend),
    .rob_to_dc_rs1_ready(rob_to_dc_rs1_ready), .rob_to_dc_rs2_ready(rob_to_dc_rs2_ready),
    .rob_to_dc_rs1_val(rob_to_dc_rs1_val), .rob_to_dc_rs2_val(rob_to_dc_rs2_val),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_val(cdb_val),
    .rob_full(rob_full), .rs_ready(rs_ready),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_imm(issue_imm), .issue_PC(issue_PC),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_depend(issue_rs1_depend), .issue_rs2_depend(issue_rs2_depend)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] inst;  logic [3:0] ot;
    logic [31:0] r1v;   logic [3:0] r1d;
    logic [31:0] r2v;   logic [3:0] r2d;
    logic        rob1;  logic [31:0] robv1;
    logic [1:0]  cv;    logic [3:0] ct0; logic [31:0] cv0; logic [3:0] ct1; logic [31:0] cv1;
    logic [31:0] e_imm; logic [4:0] e_rd;
    logic [31:0] e1v;   logic [3:0] e1d; logic [31:0] e2v; logic [3:0] e2d;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [3:0] ot, input logic [31:0] pc,
                      input logic [5:0] op);
    if_to_dc_valid  = 1'b1;
    if_to_dc_inst   = inst;
    if_to_dc_opType = ot;
    if_to_dc_PC     = pc;
    if_to_dc_op     = op;
    tick();
    if_to_dc_valid  = 1'b0;
  endtask

  task automatic clear_side();
    reg_to_dc_rs1_val = '0; reg_to_dc_rs2_val = '0;
    reg_to_dc_rs1_depend = '0; reg_to_dc_rs2_depend = '0;
    rob_to_dc_rs1_ready = 1'b0; rob_to_dc_rs2_ready = 1'b0;
    rob_to_dc_rs1_val = '0; rob_to_dc_rs2_val = '0;
    cdb_valid = '0; cdb_rob_index = '0; cdb_val = '0;
  endtask

  initial begin
    vecs[0]  = '{c_ADD, c_RC, 32'h11, 4'd0, 32'h22, 4'd0, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'h0, 5'd3, 32'h11, 4'd0, 32'h22, 4'd0};
    vecs[1]  = '{c_ADD, c_RC, 32'h5, 4'd5, 32'h6, 4'd6, 1'b1, 32'hAA, 2'b11, 4'd6, 32'hB0, 4'd6, 32'hB1,
                 32'h0, 5'd3, 32'hAA, 4'd0, 32'hB0, 4'd0};
    vecs[2]  = '{c_ADD, c_RC, 32'h7, 4'd7, 32'h33, 4'd0, 1'b0, 32'h0, 2'b01, 4'd9, 32'hC0, 4'd7, 32'hC1,
                 32'h0, 5'd3, 32'h0, 4'd7, 32'h33, 4'd0};
    vecs[3]  = '{32'h002001B3, c_RC, 32'h99, 4'd4, 32'h5, 4'd0, 1'b1, 32'hEE, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'h0, 5'd3, 32'h99, 4'd0, 32'h5, 4'd0};
    vecs[4]  = '{c_ADD, c_RC, 32'h0, 4'd6, 32'h0, 4'd8, 1'b0, 32'h0, 2'b10, 4'd6, 32'hD0, 4'd8, 32'hD1,
                 32'h0, 5'd3, 32'h0, 4'd6, 32'hD1, 4'd0};
    vecs[5]  = '{32'h123452B7, c_LUI, 32'h77, 4'd2, 32'h88, 4'd3, 1'b1, 32'hAB, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'h12345000, 5'd5, 32'h0, 4'd0, 32'h0, 4'd0};
    vecs[6]  = '{32'hFFDFF0EF, c_JAL, 32'h1, 4'd1, 32'h2, 4'd2, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'hFFFFFFFC, 5'd1, 32'h0, 4'd0, 32'h0, 4'd0};
    vecs[7]  = '{32'h008100E7, c_JALR, 32'h1000, 4'd0, 32'h55, 4'd3, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'h8, 5'd1, 32'h1000, 4'd0, 32'h0, 4'd0};
    vecs[8]  = '{32'hFE208CE3, c_BR, 32'h1, 4'd0, 32'h2, 4'd0, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'hFFFFFFF8, 5'd0, 32'h1, 4'd0, 32'h2, 4'd0};
    vecs[9]  = '{32'hFFF1A203, c_LD, 32'h300, 4'd0, 32'h9, 4'd9, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'hFFFFFFFF, 5'd4, 32'h300, 4'd0, 32'h0, 4'd0};
    vecs[10] = '{32'hFFFFF397, c_AUIPC, 32'h3, 4'd3, 32'h4, 4'd4, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'hFFFFF000, 5'd7, 32'h0, 4'd0, 32'h0, 4'd0};
    vecs[11] = '{32'hFE20AA23, c_ST, 32'h40, 4'd0, 32'h99, 4'd0, 1'b0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0,
                 32'hFFFFFFF4, 5'd0, 32'h40, 4'd0, 32'h99, 4'd0};

    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    if_to_dc_valid = 1'b0; if_to_dc_inst = '0; if_to_dc_PC = '0; if_to_dc_opType = '0; if_to_dc_op = '0;
    rob_full = 1'b0; rs_ready = 1'b1;
    clear_side();

    // Reset state
    #1;
    check("rst.issue_valid", issue_valid, 0);
    check("rst.ready", dc_to_if_ready, 1);
    check("rst.imm", issue_imm, 0);
    check("rst.PC", issue_PC, 0);
    check("rst.rs1_depend", issue_rs1_depend, 0);
    tick(); tick();
    rst_in = 1'b1;
    tick();

    // Vector table: one instruction per entry, accepted straight away
    for (int i = 0; i < 12; i++) begin
      reg_to_dc_rs1_val = vecs[i].r1v;  reg_to_dc_rs1_depend = vecs[i].r1d;
      reg_to_dc_rs2_val = vecs[i].r2v;  reg_to_dc_rs2_depend = vecs[i].r2d;
      rob_to_dc_rs1_ready = vecs[i].rob1; rob_to_dc_rs1_val = vecs[i].robv1;
      cdb_valid = vecs[i].cv;
      cdb_rob_index = {vecs[i].ct1, vecs[i].ct0};
      cdb_val = {vecs[i].cv1, vecs[i].cv0};
      push(vecs[i].inst, vecs[i].ot, 32'h100 + 32'(i*4), 6'(i + 1));
      check($sformatf("v%0d.early_valid", i), issue_valid, 0);
      tick();
      check($sformatf("v%0d.valid", i), issue_valid, 1);
      check($sformatf("v%0d.imm", i), issue_imm, vecs[i].e_imm);
      check($sformatf("v%0d.rd", i), issue_rd, vecs[i].e_rd);
      check($sformatf("v%0d.rs1_val", i), issue_rs1_val, vecs[i].e1v);
      check($sformatf("v%0d.rs1_dep", i), issue_rs1_depend, vecs[i].e1d);
      check($sformatf("v%0d.rs2_val", i), issue_rs2_val, vecs[i].e2v);
      check($sformatf("v%0d.rs2_dep", i), issue_rs2_depend, vecs[i].e2d);
      check($sformatf("v%0d.PC", i), issue_PC, 32'h100 + 32'(i*4));
      check($sformatf("v%0d.op", i), issue_op, 32'(i + 1));
      tick();
      check($sformatf("v%0d.drained", i), issue_valid, 0);
    end
    clear_side();

    // Fill: slot plus IQ_DEPTH buffered, then in-order drain
    rs_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(c_ADD, c_RC, 32'(k*4), 6'd0);
      if (k == 3) check("fill.ready_after4", dc_to_if_ready, 1);
    end
    check("fill.ready_full", dc_to_if_ready, 0);
    push(c_ADD, c_RC, 32'h80, 6'd0);
    check("fill.head_PC", issue_PC, 0);
    rs_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("fill.valid%0d", k), issue_valid, 1);
      check($sformatf("fill.PC%0d", k), issue_PC, 32'(k*4));
    end
    tick();
    check("fill.refused_never_issues", issue_valid, 0);

    // Stall snoop: ADDI x1,x2,-1 waiting on tag 3
    rs_ready = 1'b0;
    reg_to_dc_rs1_depend = 4'd3;
    push(32'hFFF10093, c_RI, 32'h200, 6'd9);
    tick();
    reg_to_dc_rs1_depend = 4'd0;
    check("snoop.rs1_dep", issue_rs1_depend, 3);
    check("snoop.imm", issue_imm, 32'hFFFFFFFF);
    check("snoop.rd", issue_rd, 1);
    tick(); tick();
    check("snoop.dep_persists", issue_rs1_depend, 3);
    cdb_valid = 2'b10; cdb_rob_index = {4'd3, 4'd0}; cdb_val = {32'h55, 32'h0};
    tick();
    cdb_valid = 2'b00;
    check("snoop.rs1_val", issue_rs1_val, 32'h55);
    check("snoop.rs1_dep_clr", issue_rs1_depend, 0);
    check("snoop.held", issue_valid, 1);
    rs_ready = 1'b1;
    tick();
    check("snoop.accepted", issue_valid, 0);
    clear_side();

    // SW held through rs_ready=0 then rob_full=1
    rs_ready = 1'b0;
    reg_to_dc_rs1_val = 32'h40; reg_to_dc_rs2_val = 32'h99;
    push(32'hFE20AA23, c_ST, 32'h300, 6'd4);
    tick();
    reg_to_dc_rs1_val = 32'h1; reg_to_dc_rs2_val = 32'h2;
    tick(); tick();
    check("sw.held_imm", issue_imm, 32'hFFFFFFF4);
    check("sw.held_rs2", issue_rs2_val, 32'h99);
    check("sw.rd", issue_rd, 0);
    rs_ready = 1'b1; rob_full = 1'b1;
    tick();
    check("sw.rob_full_hold", issue_valid, 1);
    check("sw.rob_full_PC", issue_PC, 32'h300);
    rob_full = 1'b0;
    tick();
    check("sw.accepted", issue_valid, 0);
    clear_side();

    // Flush with a buffered backlog and a same-cycle enqueue
    rs_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(c_ADD, c_RC, 32'h400 + 32'(k*4), 6'd0);
    flush_in = 1'b1; rs_ready = 1'b1;
    push(c_ADD, c_RC, 32'h3C0, 6'd0);
    flush_in = 1'b0;
    check("flush.valid", issue_valid, 0);
    check("flush.ready", dc_to_if_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flush.empty%0d", k), issue_valid, 0);
    end

    // Reset mid-stream with 3 buffered instructions
    rs_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(c_ADD, c_RC, 32'h500 + 32'(k*4), 6'd0);
    check("rstmid.pre_valid", issue_valid, 1);
    #2 rst_in = 1'b0;
    #1;
    check("rstmid.valid", issue_valid, 0);
    check("rstmid.ready", dc_to_if_ready, 1);
    check("rstmid.PC", issue_PC, 0);
    tick();
    rst_in = 1'b1;
    rs_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rstmid.nothing%0d", k), issue_valid, 0);
    end

    // LUI x5,0x12345 then freeze with rdy_in=0
    rs_ready = 1'b0;
    reg_to_dc_rs1_depend = 4'd2; reg_to_dc_rs2_depend = 4'd3;
    push(32'h123452B7, c_LUI, 32'h600, 6'd2);
    tick();
    check("lui.imm", issue_imm, 32'h12345000);
    check("lui.rs1_dep", issue_rs1_depend, 0);
    check("lui.rs2_val", issue_rs2_val, 0);
    rdy_in = 1'b0; rs_ready = 1'b1;
    if_to_dc_valid = 1'b1; if_to_dc_inst = c_ADD; if_to_dc_opType = c_RC; if_to_dc_PC = 32'h999;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("freeze.valid%0d", k), issue_valid, 1);
      check($sformatf("freeze.PC%0d", k), issue_PC, 32'h600);
    end
    check("freeze.ready", dc_to_if_ready, 1);
    if_to_dc_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    check("freeze.accepted", issue_valid, 0);
    tick();
    check("freeze.no_enqueue", issue_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
